bert_pattern_gen: RTL and testbench

- Transmit-side pattern source for the BERT: generates parallel PRBS7/15/31 or a fixed-word stream for the DUT path.
- Drives the same correct data to the error-counting backend's in_correct port.
- Optional periodic error injection flips programmed lanes and counts injected bits, so the backend's ber_count can be checked against a known total.

---
 rtl/bert_pattern_gen.sv | 187 ++++++++++++++++++
 tb/tb_bert_pattern_gen.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bert_pattern_gen.sv
// BERT transmit pattern source: PRBS7/15/31 or fixed word, with optional periodic lane-flip injection.
// Injection is built only when BERT_PATGEN_INJ_EN is defined; otherwise out_data mirrors out_correct.
module bert_pattern_gen #(
    parameter int unsigned OutWidth   = 4,
    parameter int unsigned CountWidth = 41,
    parameter int unsigned InjWidth   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            poly_sel,
    input  logic                  seed_load,
    input  logic [30:0]           seed,
    input  logic [OutWidth-1:0]   pattern,
    input  logic                  inj_enable,
    input  logic [InjWidth-1:0]   inj_interval,
    input  logic [OutWidth-1:0]   inj_mask,
    input  logic                  count_clear,
    output logic [OutWidth-1:0]   out_data,
    output logic [OutWidth-1:0]   out_correct,
    output logic                  out_valid,
    output logic [CountWidth-1:0] inj_count
);

    localparam int unsigned SeedWidth = 31;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [SeedWidth-1:0] lfsr;
    logic [SeedWidth-1:0] lfsr_mask;
    logic [SeedWidth-1:0] load_val;
    logic [SeedWidth-1:0] lfsr_src;
    logic [SeedWidth-1:0] lfsr_step;
    logic [OutWidth-1:0]  prbs_word;
    logic [OutWidth-1:0]  word_nxt;
    logic                 word_en;
    logic                 prbs_mode;
    logic                 inj_fire;
    logic                 bit_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (seed_load)   state_nxt = LOAD;
                else if (enable) state_nxt = RUN;
            end
            LOAD:    state_nxt = enable ? RUN : IDLE;
            RUN: begin
                if (seed_load)    state_nxt = LOAD;
                else if (!enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A word is produced on every edge that lands in RUN, so out_valid tracks the RUN state.
    assign word_en   = (state_nxt == RUN);
    assign prbs_mode = (poly_sel != 2'b11);

    // Seed masking and lock-up recovery: a zero state is replaced by all-ones before stepping.
    always_comb begin
        case (poly_sel)
            2'b00:   lfsr_mask = 31'h0000_007F;
            2'b01:   lfsr_mask = 31'h0000_7FFF;
            2'b10:   lfsr_mask = 31'h7FFF_FFFF;
            default: lfsr_mask = '0;
        endcase
        load_val = ((seed & lfsr_mask) == '0) ? lfsr_mask : (seed & lfsr_mask);
        lfsr_src = (state == LOAD) ? load_val : lfsr;
        if ((lfsr_src & lfsr_mask) == '0) begin
            lfsr_src = lfsr_mask;
        end
    end

    // OutWidth serial steps per clock; lane 0 holds the earliest bit.
    always_comb begin
        lfsr_step = lfsr_src;
        prbs_word = '0;
        bit_b     = 1'b0;
        for (int k = 0; k < int'(OutWidth); k++) begin
            case (poly_sel)
                2'b00: begin
                    bit_b     = lfsr_step[6] ^ lfsr_step[5];
                    lfsr_step = {24'b0, lfsr_step[5:0], bit_b};
                end
                2'b01: begin
                    bit_b     = lfsr_step[14] ^ lfsr_step[13];
                    lfsr_step = {16'b0, lfsr_step[13:0], bit_b};
                end
                2'b10: begin
                    bit_b     = lfsr_step[30] ^ lfsr_step[27];
                    lfsr_step = {lfsr_step[29:0], bit_b};
                end
                default: bit_b = 1'b0;
            endcase
            prbs_word[k] = bit_b;
        end
    end

    assign word_nxt = prbs_mode ? prbs_word : pattern;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= '1;
        end else if (state == LOAD) begin
            lfsr <= (word_en && prbs_mode) ? lfsr_step : load_val;
        end else if (word_en && prbs_mode) begin
            lfsr <= lfsr_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_correct <= '0;
            out_data    <= '0;
        end else begin
            out_valid <= word_en;
            if (word_en) begin
                out_correct <= word_nxt;
                out_data    <= inj_fire ? (word_nxt ^ inj_mask) : word_nxt;
            end
        end
    end

`ifdef BERT_PATGEN_INJ_EN
    localparam int unsigned SumWidth = CountWidth + 1;

    logic [InjWidth-1:0] inj_cnt;
    logic [InjWidth-1:0] interval_q;
    logic                inj_clr;
    logic [SumWidth-1:0] inj_pop;
    logic [SumWidth-1:0] inj_sum;

    assign inj_clr  = seed_load || !inj_enable || (inj_interval != interval_q);
    assign inj_fire = word_en && !inj_clr && (inj_interval != '0)
                   && (inj_cnt == inj_interval - InjWidth'(1));

    always_comb begin
        inj_pop = '0;
        for (int k = 0; k < int'(OutWidth); k++) begin
            inj_pop = inj_pop + SumWidth'(inj_mask[k]);
        end
        inj_sum = {1'b0, inj_count} + inj_pop;
    end

    // Interval counter and saturating injected-bit total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_cnt    <= '0;
            interval_q <= '0;
            inj_count  <= '0;
        end else begin
            interval_q <= inj_interval;
            if (inj_clr) begin
                inj_cnt <= '0;
            end else if (word_en) begin
                inj_cnt <= inj_fire ? '0 : inj_cnt + InjWidth'(1);
            end
            if (count_clear) begin
                inj_count <= '0;
            end else if (inj_fire) begin
                inj_count <= inj_sum[CountWidth] ? '1 : inj_sum[CountWidth-1:0];
            end
        end
    end
`else
    logic unused_inj;

    assign inj_fire   = 1'b0;
    assign inj_count  = '0;
    assign unused_inj = ^{inj_enable, inj_interval, inj_mask, count_clear};
`endif

endmodule

// File: tb/tb_bert_pattern_gen.sv
// Self-checking bench for bert_pattern_gen against a behavioural pattern/injection model.
module tb_bert_pattern_gen;

    localparam int unsigned OW     = 4;
    localparam int unsigned CW     = 41;
    localparam int unsigned IW     = 16;
    localparam int unsigned CW_SAT = 4;
`ifdef BERT_PATGEN_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        poly_sel;
    logic              seed_load;
    logic [30:0]       seed;
    logic [OW-1:0]     pattern;
    logic              inj_enable;
    logic [IW-1:0]     inj_interval;
    logic [OW-1:0]     inj_mask;
    logic              count_clear;
    logic [OW-1:0]     out_data, out_correct, out_data_s, out_correct_s;
    logic              out_valid, out_valid_s;
    logic [CW-1:0]     inj_count;
    logic [CW_SAT-1:0] inj_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int                m_mode;   // 0 idle, 1 loading seed, 2 running
    logic [31:0]       m_s;
    logic              m_valid;
    logic [OW-1:0]     m_correct, m_data;
    int unsigned       m_icnt;
    logic [IW-1:0]     m_prev_iv;
    longint unsigned   m_cnt, m_cnt4;

    always #5 clk = ~clk;

    bert_pattern_gen #(.OutWidth(OW), .CountWidth(CW), .InjWidth(IW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .poly_sel(poly_sel),
        .seed_load(seed_load), .seed(seed), .pattern(pattern),
        .inj_enable(inj_enable), .inj_interval(inj_interval), .inj_mask(inj_mask),
        .count_clear(count_clear), .out_data(out_data), .out_correct(out_correct),
        .out_valid(out_valid), .inj_count(inj_count)
    );

    bert_pattern_gen #(.OutWidth(OW), .CountWidth(CW_SAT), .InjWidth(IW)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .poly_sel(poly_sel),
        .seed_load(seed_load), .seed(seed), .pattern(pattern),
        .inj_enable(inj_enable), .inj_interval(inj_interval), .inj_mask(inj_mask),
        .count_clear(count_clear), .out_data(out_data_s), .out_correct(out_correct_s),
        .out_valid(out_valid_s), .inj_count(inj_count_s)
    );

    function automatic int plen(input logic [1:0] sel);
        case (sel)
            2'b00: return 7;
            2'b01: return 15;
            2'b10: return 31;
            default: return 0;
        endcase
    endfunction

    function automatic int ptap(input logic [1:0] sel);
        case (sel)
            2'b00: return 6;
            2'b01: return 14;
            2'b10: return 28;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_s = 32'h7FFF_FFFF; m_valid = 1'b0;
        m_correct = '0; m_data = '0; m_icnt = 0; m_prev_iv = '0;
        m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_step();
        int n, t, nxt, pop;
        logic [31:0] msk, base, b;
        logic [OW-1:0] w;
        bit emit, clr, fire;
        n = plen(poly_sel);
        t = ptap(poly_sel);
        msk = (n == 0) ? 32'h0 : ((32'h1 << n) - 32'h1);
        if (m_mode == 1) nxt = enable ? 2 : 0;
        else nxt = seed_load ? 1 : (enable ? 2 : 0);
        emit = (nxt == 2);
        if (m_mode == 1) begin
            base = {1'b0, seed} & msk;
            if (base == 0) base = msk;
        end else begin
            base = m_s;
        end
        w = m_correct;
        if (emit && n != 0) begin
            if ((base & msk) == 0) base = msk;
            for (int k = 0; k < int'(OW); k++) begin
                b = ((base >> (n - 1)) ^ (base >> (t - 1))) & 32'h1;
                w[k] = b[0];
                base = ((base << 1) | b) & msk;
            end
            m_s = base;
        end else begin
            if (emit) w = pattern;
            if (m_mode == 1) m_s = base;
        end
        clr  = seed_load || !inj_enable || (inj_interval != m_prev_iv);
        fire = INJ && emit && !clr && (inj_interval != 0) && (m_icnt == inj_interval - 1);
        if (clr) m_icnt = 0;
        else if (emit) m_icnt = fire ? 0 : ((m_icnt + 1) & 32'hFFFF);
        if (emit) begin
            m_correct = w;
            m_data = fire ? (w ^ inj_mask) : w;
        end
        m_valid = emit;
        pop = $countones(inj_mask);
        if (INJ) begin
            if (count_clear) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if (fire) begin
                m_cnt  = (m_cnt + pop > (64'h1 << CW) - 1) ? (64'h1 << CW) - 1 : m_cnt + pop;
                m_cnt4 = (m_cnt4 + pop > 15) ? 15 : m_cnt4 + pop;
            end
        end
        m_prev_iv = inj_interval;
        m_mode = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 0; poly_sel = 0; seed_load = 0; seed = '0; pattern = '0;
        inj_enable = 0; inj_interval = '0; inj_mask = '0; count_clear = 0;
        #2;
        model_reset();
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_correct} !== 9'b0 || inj_count !== '0 || inj_count_s !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got v=%0b d=%0h c=%0h cnt=%0h expected all zero",
                     out_valid, out_data, out_correct, inj_count);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_correct !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got v=%0b c=%0h expected v=0 c=0", out_valid, out_correct);
        end
    endtask

    task automatic test_prbs7();
        logic [OW-1:0] words [254];
        bit varied;
        poly_sel = 2'b00; seed = 31'h7F; seed_load = 1; enable = 0;
        tick();
        seed_load = 0; enable = 1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL prbs7_load_valid: got %0b expected 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_correct !== 4'b0000) begin
            n_bad++; $display("FAIL prbs7_word0: got v=%0b c=%b expected v=1 c=0000", out_valid, out_correct);
        end
        tick();
        n_cmp++;
        if (out_correct !== 4'b0100) begin
            n_bad++; $display("FAIL prbs7_word1: got %b expected 0100", out_correct);
        end
        for (int i = 0; i < 254; i++) begin
            tick();
            words[i] = out_correct;
            n_cmp++;
            if ({out_valid, out_correct, out_data} !== {m_valid, m_correct, m_data}) begin
                n_bad++;
                $display("FAIL prbs7_stream[%0d]: got v=%0b c=%h d=%h expected v=%0b c=%h d=%h",
                         i, out_valid, out_correct, out_data, m_valid, m_correct, m_data);
            end
        end
        varied = 0;
        for (int i = 0; i < 127; i++) begin
            if (words[i] != words[i + 1]) varied = 1;
            n_cmp++;
            if (words[i] !== words[i + 127]) begin
                n_bad++;
                $display("FAIL prbs7_period[%0d]: got %h expected %h", i, words[i + 127], words[i]);
            end
        end
        n_cmp++;
        if (!varied) begin
            n_bad++; $display("FAIL prbs7_varied: got constant stream expected varying words");
        end
    endtask

    task automatic test_lockup();
        int changes;
        bit nonzero;
        logic [OW-1:0] prev;
        enable = 0; tick();
        poly_sel = 2'b10; seed = '0; seed_load = 1; tick();
        seed_load = 0; enable = 1; tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_correct !== 4'b0000 || m_correct !== 4'b0000) begin
            n_bad++; $display("FAIL lockup_prbs31_first: got v=%0b c=%h expected v=1 c=0", out_valid, out_correct);
        end
        changes = 0; nonzero = 0; prev = out_correct;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_correct != prev) changes++;
            if (out_correct != 0) nonzero = 1;
            prev = out_correct;
            n_cmp++;
            if ({out_valid, out_correct, out_data} !== {m_valid, m_correct, m_data}) begin
                n_bad++;
                $display("FAIL lockup_prbs31_stream[%0d]: got c=%h expected c=%h", i, out_correct, m_correct);
            end
        end
        n_cmp++;
        if (changes == 0 || !nonzero) begin
            n_bad++; $display("FAIL lockup_prbs31_live: got changes=%0d nonzero=%0b expected >0 and 1", changes, nonzero);
        end
        enable = 0; tick();
        seed = 31'h80; seed_load = 1; tick();
        seed_load = 0; tick();
        poly_sel = 2'b00; enable = 1; tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_correct !== 4'b0000) begin
            n_bad++; $display("FAIL lockup_switch_word0: got v=%0b c=%b expected v=1 c=0000", out_valid, out_correct);
        end
        tick();
        n_cmp++;
        if (out_correct !== 4'b0100 || m_correct !== 4'b0100) begin
            n_bad++; $display("FAIL lockup_switch_word1: got %b expected 0100", out_correct);
        end
    endtask

    task automatic test_injection();
        int hits, other;
        logic [OW-1:0] diff;
        enable = 0; count_clear = 1; inj_interval = 16'd10; inj_mask = 4'b0101; inj_enable = 1;
        poly_sel = 2'($urandom_range(0, 2)); seed = 31'($urandom);
        tick();
        count_clear = 0; seed_load = 1; tick();
        seed_load = 0; enable = 1;
        hits = 0; other = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            diff = out_data ^ out_correct;
            if (diff == 4'b0101) hits++;
            else if (diff != 0) other++;
            n_cmp++;
            if ({out_valid, out_correct, out_data} !== {m_valid, m_correct, m_data} || inj_count !== CW'(m_cnt)) begin
                n_bad++;
                $display("FAIL inj_stream[%0d]: got c=%h d=%h cnt=%0d expected c=%h d=%h cnt=%0d",
                         i, out_correct, out_data, inj_count, m_correct, m_data, m_cnt);
            end
        end
        n_cmp++;
        if (hits != (INJ ? 100 : 0) || other != 0) begin
            n_bad++; $display("FAIL inj_hits: got %0d (other %0d) expected %0d (other 0)", hits, other, INJ ? 100 : 0);
        end
        n_cmp++;
        if (inj_count !== CW'(INJ ? 200 : 0)) begin
            n_bad++; $display("FAIL inj_total: got %0d expected %0d", inj_count, INJ ? 200 : 0);
        end
    endtask

    task automatic test_fixed_toggle();
        enable = 0; count_clear = 1; inj_interval = '0; inj_enable = 1; inj_mask = 4'hF;
        poly_sel = 2'b11; pattern = 4'hA;
        tick();
        count_clear = 0; enable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_correct !== 4'hA || out_data !== 4'hA) begin
                n_bad++; $display("FAIL fixed_run[%0d]: got v=%0b c=%h d=%h expected v=1 c=a d=a", i, out_valid, out_correct, out_data);
            end
        end
        enable = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || out_correct !== 4'hA || out_data !== 4'hA) begin
                n_bad++; $display("FAIL fixed_hold[%0d]: got v=%0b c=%h d=%h expected v=0 c=a d=a", i, out_valid, out_correct, out_data);
            end
        end
        enable = 1; pattern = 4'h3; tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_correct !== 4'h3) begin
            n_bad++; $display("FAIL fixed_pattern_change: got v=%0b c=%h expected v=1 c=3", out_valid, out_correct);
        end
        n_cmp++;
        if (inj_count !== '0) begin
            n_bad++; $display("FAIL fixed_no_inject: got %0d expected 0", inj_count);
        end
    endtask

    task automatic test_saturation();
        int expv;
        enable = 0; count_clear = 1; inj_mask = 4'hF; inj_interval = 16'd1; inj_enable = 1; poly_sel = 2'b00;
        tick();
        count_clear = 0; enable = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            expv = INJ ? ((4 * i > 15) ? 15 : 4 * i) : 0;
            n_cmp++;
            if (inj_count_s !== CW_SAT'(expv) || inj_count !== CW'(INJ ? 4 * i : 0)) begin
                n_bad++; $display("FAIL sat_count[%0d]: got sat=%0d wide=%0d expected sat=%0d wide=%0d",
                                  i, inj_count_s, inj_count, expv, INJ ? 4 * i : 0);
            end
        end
        count_clear = 1; tick();
        count_clear = 0;
        n_cmp++;
        if (inj_count_s !== '0 || inj_count !== '0) begin
            n_bad++; $display("FAIL sat_clear_priority: got sat=%0d wide=%0d expected 0", inj_count_s, inj_count);
        end
        tick();
        n_cmp++;
        if (inj_count_s !== CW_SAT'(INJ ? 4 : 0)) begin
            n_bad++; $display("FAIL sat_after_clear: got %0d expected %0d", inj_count_s, INJ ? 4 : 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable      = ($urandom_range(0, 7) != 0);
            seed_load   = ($urandom_range(0, 31) == 0);
            seed        = 31'($urandom);
            if ($urandom_range(0, 39) == 0) poly_sel = 2'($urandom_range(0, 3));
            pattern     = 4'($urandom);
            inj_enable  = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) inj_interval = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 31) == 0) inj_mask = 4'($urandom);
            count_clear = ($urandom_range(0, 49) == 0);
            tick();
            n_cmp++;
            if ({out_valid, out_correct, out_data} !== {m_valid, m_correct, m_data}
                || {out_valid_s, out_correct_s, out_data_s} !== {m_valid, m_correct, m_data}
                || inj_count !== CW'(m_cnt) || inj_count_s !== CW_SAT'(m_cnt4)) begin
                n_bad++;
                $display("FAIL random[%0d]: got v=%0b c=%h d=%h cnt=%0d sat=%0d expected v=%0b c=%h d=%h cnt=%0d sat=%0d",
                         i, out_valid, out_correct, out_data, inj_count, inj_count_s,
                         m_valid, m_correct, m_data, m_cnt, m_cnt4);
            end
        end
        seed_load = 0; count_clear = 0;
    endtask

    task automatic test_reset_midrun();
        poly_sel = 2'b00; enable = 1; inj_enable = 1; inj_interval = 16'd2; inj_mask = 4'h1;
        repeat (5) tick();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({out_valid, out_data, out_correct} !== 9'b0 || inj_count !== '0) begin
            n_bad++; $display("FAIL midrun_reset_async: got v=%0b d=%h c=%h cnt=%0d expected all zero",
                              out_valid, out_data, out_correct, inj_count);
        end
        tick();
        reset = 1'b0; inj_enable = 0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_correct !== 4'b0000) begin
            n_bad++; $display("FAIL midrun_restart_word0: got v=%0b c=%b expected v=1 c=0000", out_valid, out_correct);
        end
        tick();
        n_cmp++;
        if (out_correct !== 4'b0100 || out_data !== 4'b0100) begin
            n_bad++; $display("FAIL midrun_restart_word1: got c=%b d=%b expected 0100", out_correct, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_prbs7();
        test_lockup();
        test_injection();
        test_fixed_toggle();
        test_saturation();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
